// File: rtl/irom_fetch_ctrl.sv
// Instruction ROM port sequencer: sequential prefetch into a small queue feeding decode,
// with a low-priority debug read port protected against starvation.
module irom_fetch_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [13:0] irom_a,
  input  logic [31:0] irom_spo,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  input  logic        dbg_req,
  input  logic [13:0] dbg_addr,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 2);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             dbg_rvalid_q;
  logic [31:0]      dbg_rdata_q, dbg_rdata_d;
  logic             pop, slot, push, full, starved;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign starved  = (starve_q == STV_W'(STARVE_MAX));
  assign if_valid = (count_q != '0);
  assign if_pc    = pc_mem[rptr_q];
  assign if_instr = instr_mem[rptr_q];

  assign pop     = if_valid & if_ready & ~redirect_valid;
  assign slot    = fetch_en & ~redirect_valid & (~full | pop);
  // Debug wins whenever fetch cannot use the port, or once it has waited long enough.
  assign dbg_gnt = dbg_req & (~slot | starved);
  assign push    = slot & ~dbg_gnt;
  assign irom_a  = dbg_gnt ? dbg_addr : fetch_pc_q[15:2];

  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

  always_comb begin
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    fetch_pc_d  = fetch_pc_q;
    starve_d    = '0;
    dbg_rdata_d = dbg_rdata_q;

    if (redirect_valid) begin
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      if (push) begin
        wptr_d     = wptr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end

    if (dbg_req && !dbg_gnt) begin
      starve_d = starved ? starve_q : starve_q + 1'b1;
    end
    if (dbg_gnt) begin
      dbg_rdata_d = irom_spo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      fetch_pc_q   <= RESET_PC & 32'hFFFF_FFFC;
      starve_q     <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      fetch_pc_q   <= fetch_pc_d;
      starve_q     <= starve_d;
      dbg_rvalid_q <= dbg_gnt;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q]    <= fetch_pc_q;
      instr_mem[wptr_q] <= irom_spo;
    end
  end

endmodule

// File: doc/irom_fetch_ctrl.md
Name: irom_fetch_ctrl

Overview:
- Sequences the single combinational read port of the 16K×32 instruction ROM (14-bit word address, 32-bit data).
- Fetch path: fetches sequentially from a PC register into a small prefetch queue, which feeds decode over a valid/ready handshake. Branch/jump redirects flush the queue.
- Debug path: shares the ROM port with a low-priority debug/self-check read port, guarded by a starvation limit.

Parameters:
- DEPTH, 4, prefetch queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- STARVE_MAX, 7, consecutive ungranted debug-request cycles before debug is forced a grant.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irom_a  out  14  ROM word address.
- irom_spo  in  32  ROM data, combinational from irom_a.
- fetch_en  in  1  1 = fetching permitted.
- redirect_valid  in  1  pipeline redirect pulse.
- redirect_pc  in  32  redirect target byte address.
- if_valid  out  1  queue head valid.
- if_pc  out  32  queue head PC.
- if_instr  out  32  queue head instruction.
- if_ready  in  1  decode accepts head.
- dbg_req  in  1  debug read request; held until granted.
- dbg_addr  in  14  debug word address.
- dbg_gnt  out  1  debug owns ROM this cycle (combinational).
- dbg_rvalid  out  1  one-cycle pulse, debug data valid.
- dbg_rdata  out  32  registered debug read data.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC (bits [1:0] forced 0); queue count = 0, read/write pointers = 0.
  - dbg_rvalid = 0, dbg_rdata = 0, starvation counter = 0.
  - Hence if_valid = 0 and dbg_gnt = 0 while reset is asserted.
- One ROM access per cycle. irom_a = dbg_gnt ? dbg_addr : fetch_pc[15:2]. Addresses wrap modulo 64 KiB.
- pop = if_valid & if_ready & ~redirect_valid.
- Fetch slot is available when: fetch_en = 1, redirect_valid = 0, and (count < DEPTH or pop).
- dbg_gnt = dbg_req & (~fetch_slot_available | starve_cnt == STARVE_MAX).
- fetch_push = fetch_slot_available & ~dbg_gnt.
  - On push: write {fetch_pc, irom_spo} at the write pointer; fetch_pc += 4, wrapping at 2^32.
- Push and pop in the same cycle leave count unchanged. A push into a full queue is legal only when a pop occurs in that cycle.
- if_valid = (count != 0). if_pc and if_instr are driven combinationally from the head entry; they are stable while if_valid = 1 and if_ready = 0.
- Redirect (cycle N), at the edge:
  - count = 0, pointers = 0, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any pop in cycle N is ignored; no push occurs in cycle N.
  - Timing: if_valid = 0 in N+1; target is fetched in N+1; if_valid = 1 with if_pc = target in N+2.
  - The cycle-N ROM slot is free, so dbg_gnt may assert in cycle N.
- Debug:
  - On a grant in cycle N: dbg_rdata = irom_spo, dbg_rvalid = 1 for cycle N+1 only.
  - Back-to-back grants give back-to-back pulses.
  - dbg_addr is sampled only in the grant cycle.
- Starvation counter:
  - Increments each cycle dbg_req = 1 & dbg_gnt = 0, saturating at STARVE_MAX.
  - Clears on grant or when dbg_req = 0.
- fetch_en = 0: no pushes; the queue still drains; debug is granted on its first request cycle.
- Mid-operation reset: all state returns to reset values immediately, and any in-flight dbg_rvalid is suppressed.

Test Plan:
1. Reset release; fetch_en = 1, if_ready = 1, ROM word i = 32'h1000_0000+i -> if_valid first in cycle 2. if_pc = 0, 4, 8, … each cycle with if_instr = 32'h1000_0000, …0001, …0002.
2. if_ready = 0 for 10 cycles -> count saturates at 4, if_pc holds 0, fetch_pc = 16. Then set if_ready = 1 -> entries 0, 4, 8, 12, 16 in order, no gaps, no duplicates.
3. Redirect to 32'h0000_0103 in cycle N while the queue is full -> if_valid = 0 in N+1. In N+2, if_pc = 32'h0000_0100 and if_instr = ROM[64]. Stale entries are never presented.
4. Queue full, if_ready = 0, dbg_req with dbg_addr = 14'h3FFF -> dbg_gnt same cycle, irom_a = 14'h3FFF. Next cycle dbg_rvalid = 1 for one cycle, with dbg_rdata = ROM[16383].
5. if_ready = 1 continuously, dbg_req held from cycle T -> dbg_gnt = 0 for 7 cycles and asserts in cycle T+7. No fetch push that cycle; the queue shows a one-entry bubble but the PC sequence stays contiguous.
6. rst_n low mid-stream with dbg grant pending rvalid -> if_valid = 0 and dbg_rvalid = 0 immediately. After release, fetch restarts at RESET_PC.
